// File: rtl/node_output_queue.sv
// Per-port output buffering for a ring node: three independent FIFOs fed by the
// routing controller, drained over valid/ready, with saturating drop accounting.
module node_output_queue #(
    parameter int DEPTH  = 4,
    parameter int PTR_W  = 2,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [1:0]        in_port,
    input  logic [DATA_W-1:0] in_instr,
    output logic [2:0]        out_valid,
    input  logic [2:0]        out_ready,
    output logic [DATA_W-1:0] out_data0,
    output logic [DATA_W-1:0] out_data1,
    output logic [DATA_W-1:0] out_data2,
    output logic [2:0]        port_full,
    output logic [CNT_W-1:0]  drop_count,
    output logic              illegal_seen
);

    localparam int NPORT = 3;
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_INC  = {{PTR_W{1'b0}}, 1'b1};
    localparam logic [PTR_W-1:0] PTR_INC  = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] DROP_INC = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [DATA_W-1:0] mem    [NPORT][DEPTH];
    logic [PTR_W-1:0]  wr_ptr [NPORT];
    logic [PTR_W-1:0]  rd_ptr [NPORT];
    logic [PTR_W:0]    count  [NPORT];
    logic [DATA_W-1:0] head   [NPORT];

    logic [NPORT-1:0] push;
    logic [NPORT-1:0] pop;
    logic [NPORT-1:0] full;
    logic [NPORT-1:0] empty;
    logic             illegal;
    logic             drop;

    // Full/empty come from the count at the start of the cycle, so a full port
    // rejects a push even when it pops on the same edge.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        push    = '0;
        pop     = '0;
        full    = '0;
        empty   = '0;
        illegal = in_valid && (in_port == 2'b11);
        drop    = illegal;
        for (int i = 0; i < NPORT; i++) begin
            head[i]  = '0;
            full[i]  = (count[i] == FULL_CNT);
            empty[i] = (count[i] == '0);
            push[i]  = in_valid && (in_port == 2'(i)) && !full[i];
            pop[i]   = !empty[i] && out_ready[i];
            if (in_valid && (in_port == 2'(i)) && full[i])
                drop = 1'b1;
            if (!empty[i])
                head[i] = mem[i][rd_ptr[i]];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NPORT; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NPORT; i++) begin
                if (push[i])
                    wr_ptr[i] <= wr_ptr[i] + PTR_INC;
                if (pop[i])
                    rd_ptr[i] <= rd_ptr[i] + PTR_INC;
                case ({push[i], pop[i]})
                    2'b10:   count[i] <= count[i] + CNT_INC;
                    2'b01:   count[i] <= count[i] - CNT_INC;
                    default: count[i] <= count[i];
                endcase
            end
        end
    end

    // NOTE: storage is not reset; empty ports mask their head to zero, so contents are don't-care.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NPORT; i++) begin
            if (push[i])
                mem[i][wr_ptr[i]] <= in_instr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_count   <= '0;
            illegal_seen <= 1'b0;
        end else begin
            if (drop && (drop_count != '1))
                drop_count <= drop_count + DROP_INC;
            if (illegal)
                illegal_seen <= 1'b1;
        end
    end

    assign out_valid = ~empty;
    assign port_full = full;
    assign out_data0 = head[0];
    assign out_data1 = head[1];
    assign out_data2 = head[2];

endmodule

// File: tb/tb_node_output_queue.sv
// Self-checking bench for node_output_queue: directed scenarios plus random
// traffic compared every cycle against a queue-based reference model.
module tb_node_output_queue;

    localparam int DEPTH  = 4;
    localparam int PTR_W  = 2;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 8;
    localparam int DROP_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic [1:0]        in_port;
    logic [DATA_W-1:0] in_instr;
    logic [2:0]        out_valid;
    logic [2:0]        out_ready;
    logic [DATA_W-1:0] out_data0;
    logic [DATA_W-1:0] out_data1;
    logic [DATA_W-1:0] out_data2;
    logic [2:0]        port_full;
    logic [CNT_W-1:0]  drop_count;
    logic              illegal_seen;

    node_output_queue #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W),
        .DATA_W(DATA_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_port     (in_port),
        .in_instr    (in_instr),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data0   (out_data0),
        .out_data1   (out_data1),
        .out_data2   (out_data2),
        .port_full   (port_full),
        .drop_count  (drop_count),
        .illegal_seen(illegal_seen)
    );

    always #5 clk = ~clk;

    int n_compared   = 0;
    int n_mismatched = 0;

    // Reference model: one queue per port plus the drop/illegal bookkeeping.
    logic [DATA_W-1:0] mq0[$];
    logic [DATA_W-1:0] mq1[$];
    logic [DATA_W-1:0] mq2[$];
    int                m_drops;
    bit                m_illegal;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int qsize(input int p);
        case (p)
            0:       return mq0.size();
            1:       return mq1.size();
            default: return mq2.size();
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] qhead(input int p);
        if (qsize(p) == 0) return '0;
        case (p)
            0:       return mq0[0];
            1:       return mq1[0];
            default: return mq2[0];
        endcase
    endfunction

    task automatic model_clear();
        mq0.delete();
        mq1.delete();
        mq2.delete();
        m_drops   = 0;
        m_illegal = 1'b0;
    endtask

    // Apply one clock edge of the specified behaviour using pre-edge occupancy.
    task automatic model_edge(input logic v, input logic [1:0] p,
                              input logic [DATA_W-1:0] instr, input logic [2:0] rdy);
        bit do_push = 1'b0;
        bit do_drop = 1'b0;
        if (v) begin
            if (p == 2'b11) begin
                do_drop   = 1'b1;
                m_illegal = 1'b1;
            end else if (qsize(int'(p)) == DEPTH) begin
                do_drop = 1'b1;
            end else begin
                do_push = 1'b1;
            end
        end
        if (rdy[0] && mq0.size() != 0) void'(mq0.pop_front());
        if (rdy[1] && mq1.size() != 0) void'(mq1.pop_front());
        if (rdy[2] && mq2.size() != 0) void'(mq2.pop_front());
        if (do_push) begin
            case (p)
                2'd0:    mq0.push_back(instr);
                2'd1:    mq1.push_back(instr);
                default: mq2.push_back(instr);
            endcase
        end
        if (do_drop && m_drops < DROP_MAX) m_drops++;
    endtask

    task automatic check_outputs(input string tag);
        logic [2:0] ev;
        logic [2:0] ef;
        for (int i = 0; i < 3; i++) begin
            ev[i] = (qsize(i) != 0);
            ef[i] = (qsize(i) == DEPTH);
        end
        check({tag, "/out_valid"}, 64'(out_valid), 64'(ev));
        check({tag, "/port_full"}, 64'(port_full), 64'(ef));
        check({tag, "/out_data0"}, 64'(out_data0), 64'(qhead(0)));
        check({tag, "/out_data1"}, 64'(out_data1), 64'(qhead(1)));
        check({tag, "/out_data2"}, 64'(out_data2), 64'(qhead(2)));
        check({tag, "/drop_count"}, 64'(drop_count), 64'(m_drops));
        check({tag, "/illegal_seen"}, 64'(illegal_seen), 64'(m_illegal));
    endtask

    // Called just after a falling edge: drive, check state, advance one edge.
    task automatic cycle(input string tag, input logic v, input logic [1:0] p,
                         input logic [DATA_W-1:0] instr, input logic [2:0] rdy);
        in_valid  = v;
        in_port   = p;
        in_instr  = instr;
        out_ready = rdy;
        #1;
        check_outputs(tag);
        @(posedge clk);
        model_edge(v, p, instr, rdy);
        @(negedge clk);
    endtask

    // Asynchronous reset asserted between clock edges, checked before any edge.
    task automatic mid_cycle_reset(input string tag);
        in_valid  = 1'b0;
        out_ready = 3'b000;
        #2;
        rst_n = 1'b0;
        #1;
        check({tag, "/rst_valid"}, 64'(out_valid), 64'(0));
        check({tag, "/rst_full"}, 64'(port_full), 64'(0));
        check({tag, "/rst_data"}, 64'({out_data0, out_data1, out_data2} != '0), 64'(0));
        check({tag, "/rst_drops"}, 64'(drop_count), 64'(0));
        check({tag, "/rst_illegal"}, 64'(illegal_seen), 64'(0));
        model_clear();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_port   = 2'b00;
        in_instr  = '0;
        out_ready = 3'b000;
        model_clear();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cycle("reset_idle", 1'b0, 2'd0, '0, 3'b000);

        // Single route to the local sink, then consume it.
        cycle("single_push", 1'b1, 2'd1, 32'h6000_0ABC, 3'b000);
        check("single_head", 64'(out_data1), 64'h6000_0ABC);
        cycle("single_pop", 1'b0, 2'd0, '0, 3'b010);
        cycle("single_empty", 1'b0, 2'd0, '0, 3'b000);

        // Fill port 2 past capacity, then drain in order.
        for (int k = 1; k <= 5; k++)
            cycle("fill2", 1'b1, 2'd2, DATA_W'(k), 3'b000);
        check("fill2_full", 64'(port_full), 64'b100);
        check("fill2_drop", 64'(drop_count), 64'd1);
        for (int k = 1; k <= 4; k++) begin
            check("drain2_order", 64'(out_data2), 64'(k));
            cycle("drain2", 1'b0, 2'd0, '0, 3'b100);
        end
        check("drain2_empty", 64'(out_valid[2]), 64'd0);

        // Simultaneous push/pop on a partly filled and on a full port 0.
        cycle("pp_a", 1'b1, 2'd0, 32'h11, 3'b000);
        cycle("pp_b", 1'b1, 2'd0, 32'h22, 3'b000);
        cycle("pp_mid", 1'b1, 2'd0, 32'hAA, 3'b001);
        check("pp_head", 64'(out_data0), 64'h22);
        cycle("pp_fill", 1'b1, 2'd0, 32'h33, 3'b000);
        cycle("pp_fill", 1'b1, 2'd0, 32'h44, 3'b000);
        check("pp_full", 64'(port_full[0]), 64'd1);
        cycle("pp_fullpush", 1'b1, 2'd0, 32'hBB, 3'b001);
        check("pp_fulldrop", 64'(drop_count), 64'd2);
        for (int k = 0; k < 4; k++)
            cycle("pp_drain", 1'b0, 2'd0, '0, 3'b001);

        // Push to an empty port with ready high: no same-cycle pop.
        cycle("empty_rdy", 1'b1, 2'd2, 32'h77, 3'b100);
        check("empty_rdy_valid", 64'(out_valid[2]), 64'd1);
        cycle("empty_rdy_pop", 1'b0, 2'd0, '0, 3'b100);

        // Illegal routing code is sticky and counted.
        cycle("illegal", 1'b1, 2'd3, 32'hDEAD_BEEF, 3'b000);
        check("illegal_flag", 64'(illegal_seen), 64'd1);
        for (int k = 0; k < 4; k++)
            cycle("illegal_after", 1'b1, 2'($urandom_range(0, 2)), $urandom, 3'b111);

        // Saturate the drop counter into a full port 0.
        for (int k = 0; k < DEPTH; k++)
            cycle("sat_fill", 1'b1, 2'd0, 32'hC000_0000 | DATA_W'(k), 3'b000);
        for (int k = 0; k < 300; k++) begin
            in_valid = 1'b1;
            in_port  = 2'd0;
            in_instr = $urandom;
            out_ready = 3'b000;
            @(posedge clk);
            model_edge(1'b1, 2'd0, in_instr, 3'b000);
            @(negedge clk);
        end
        check_outputs("sat");
        check("sat_hold", 64'(drop_count), 64'(DROP_MAX));

        // Pointer wrap on port 1: 3*DEPTH back-to-back push/pop.
        for (int k = 0; k < 3 * DEPTH; k++)
            cycle("wrap1", 1'b1, 2'd1, $urandom, 3'b010);
        cycle("wrap1_tail", 1'b0, 2'd0, '0, 3'b010);

        mid_cycle_reset("reset_mid");
        cycle("post_reset", 1'b0, 2'd0, '0, 3'b111);

        // Random traffic with biased stalls so ports fill and drop.
        for (int k = 0; k < 1500; k++) begin
            logic       v;
            logic [1:0] p;
            logic [2:0] r;
            v = ($urandom_range(0, 3) != 0);
            p = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            r = 3'($urandom) & 3'($urandom);
            cycle("random", v, p, $urandom, r);
        end

        mid_cycle_reset("reset_end");
        cycle("final_idle", 1'b0, 2'd0, '0, 3'b000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/node_output_queue.md
Name: node_output_queue

Overview:
- Sits directly downstream of the node routing controller in each ring node.
- Consumes the controller's registered routing decision (2-bit port enable), the instruction word and the valid flag.
- Buffers each instruction in a per-output-port FIFO and presents it to the neighbouring node or the local sink over a valid/ready handshake.
- Counts instructions it must discard, because the upstream controller cannot stall.

Parameters:
- DEPTH, 4, entries per output FIFO; power of two, minimum 2.
- PTR_W, 2, log2(DEPTH); pointer width.
- DATA_W, 32, instruction word width.
- CNT_W, 8, width of the drop counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  instruction valid; driven by the controller's registered enable-out.
- in_port  input  2  routing decision from the controller: 00 = port 0 (ring direction A), 01 = port 1 (local sink), 10 = port 2 (ring direction B), 11 = illegal.
- in_instr  input  DATA_W  instruction word from the controller's registered output.
- out_valid  output  3  per-port head-of-queue valid; bit i belongs to port i.
- out_ready  input  3  per-port consumer ready.
- out_data0  output  DATA_W  head entry of port 0.
- out_data1  output  DATA_W  head entry of port 1.
- out_data2  output  DATA_W  head entry of port 2.
- port_full  output  3  per-port FIFO full (count == DEPTH).
- drop_count  output  CNT_W  saturating count of discarded instructions.
- illegal_seen  output  1  sticky flag: an instruction arrived with in_port = 11.

Behaviour:
- Reset (asynchronous, rst_n low):
  - all FIFO counts and pointers go to 0;
  - out_valid = 000, port_full = 000, drop_count = 0, illegal_seen = 0;
  - out_dataN = 0; storage contents are don't-care, but out_data is forced to 0 while the port is empty.
- Reset mid-operation discards all queued entries immediately; nothing is replayed after release.
- in_valid, in_port and in_instr are aligned in the same cycle; the upstream stage registers all three on the same edge.
- Write: at a rising edge with in_valid = 1 and in_port = k (k in 0..2):
  - if FIFO k is not full at the start of the cycle, in_instr is written at its write pointer, the pointer increments and wraps modulo DEPTH, and the count increments;
  - otherwise the instruction is dropped.
- A full FIFO rejects a write even if the same cycle pops it. This is a fixed, deterministic rule with no pass-through.
- Illegal code: in_valid = 1 with in_port = 11 → dropped and illegal_seen set to 1. The flag clears only on reset.
- Drop counting: every dropped instruction (full target or illegal code) increments drop_count by 1. The counter saturates at 2^CNT_W-1 and never wraps.
- Read (per port i):
  - out_valid[i] = (count_i != 0), registered-state derived;
  - out_dataN = storage[rd_ptr_i], combinational from registered storage;
  - pop occurs at an edge where out_valid[i] & out_ready[i];
  - on pop, the read pointer increments modulo DEPTH and the count decrements.
- out_ready while empty has no effect.
- Simultaneous push and pop on the same non-full, non-empty port leaves the count unchanged; both pointers advance.
- Push to an empty port plus out_ready high in the same cycle: no pop occurs, because the port was empty at the start of the cycle.
- Latency: an instruction written at edge N is visible (out_valid high, data valid) in the cycle after edge N. There is no bypass.
- Ports are independent. A stall on one port never blocks the others, and at most one push occurs per cycle.
- port_full[i] reflects count_i == DEPTH and is registered-state derived.
- in_valid = 0: in_port and in_instr are ignored.
- Ordering is FIFO per port; there are no ordering guarantees across ports.

Test Plan:
- Reset then idle: assert rst_n low mid-cycle → all outputs 0 asynchronously; after release, out_valid = 000 and drop_count = 0.
- Single route: in_valid = 1, in_port = 01, in_instr = 0x60000ABC at edge N → out_valid = 010 and out_data1 = 0x60000ABC after edge N; out_ready[1] = 1 → out_valid = 000 after the next edge.
- Fill and drop: out_ready = 000; push 5 words 0x1..0x5 to port 2 → port_full = 100, drop_count = 1; then drain with out_ready[2] = 1 → out_data2 sequence 1, 2, 3, 4, and out_valid[2] deasserts after 4 pops.
- Simultaneous push/pop: port 0 holding 2 entries, push 0xAA while popping → count stays 2 and the head advances; port 0 full with push plus pop in the same cycle → pop occurs, push dropped, drop_count +1.
- Illegal code: in_valid = 1, in_port = 11 → no out_valid change, illegal_seen = 1, drop_count +1; illegal_seen stays 1 through further traffic until rst_n.
- Saturation and wrap: stream 300 drops into a full port → drop_count holds 255. Then run 3×DEPTH push/pop cycles on port 1 → data order is preserved across pointer wrap-around.
